// File: rtl/i2c_slave_responder_if.sv
// Bus and user-side signal bundle for the I2C target responder.
// The slave modport is the responder's view; the master modport is the
// view of whatever owns the pads and the user data path.
interface i2c_slave_responder_if;
  logic       scl_i;
  logic       sda_i;
  logic       scl_oe;
  logic       sda_oe;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       start_det;
  logic       stop_det;
  logic       nack_rcvd;

  modport slave (
    input  scl_i,
    input  sda_i,
    input  rd_data,
    input  rd_valid,
    output scl_oe,
    output sda_oe,
    output wr_data,
    output wr_valid,
    output rd_req,
    output busy,
    output start_det,
    output stop_det,
    output nack_rcvd
  );

  modport master (
    output scl_i,
    output sda_i,
    output rd_data,
    output rd_valid,
    input  scl_oe,
    input  sda_oe,
    input  wr_data,
    input  wr_valid,
    input  rd_req,
    input  busy,
    input  start_det,
    input  stop_det,
    input  nack_rcvd
  );
endinterface

// File: rtl/i2c_slave_responder.sv
// I2C target: detects START/STOP, matches a 7-bit address, ACKs written
// bytes and hands them to user logic, and serves read bytes fetched from
// user logic while stretching SCL until the byte is available.
// SCL/SDA are oversampled by clk; every decision uses the synchronized copy.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h22,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  i2c_slave_responder_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    WR_BYTE   = 4'd3,
    WR_ACK    = 4'd4,
    RD_FETCH  = 4'd5,
    RD_BYTE   = 4'd6,
    RD_ACK    = 4'd7,
    IGNORE    = 4'd8,
    WAIT_STOP = 4'd9
  } state_e;

  // Synchronizer chains and one history flop each for edge detection.
  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_hist_q;
  logic                   sda_hist_q;

  // Protocol state.
  state_e     state_q,   state_d;
  logic [3:0] cnt_q,     cnt_d;
  logic [7:0] shift_q,   shift_d;
  logic       rw_q,      rw_d;

  // Registered outputs.
  logic       sda_oe_q,   sda_oe_d;
  logic       scl_oe_q,   scl_oe_d;
  logic [7:0] wr_data_q,  wr_data_d;
  logic       wr_valid_q, wr_valid_d;
  logic       rd_req_q,   rd_req_d;
  logic       busy_q,     busy_d;
  logic       start_q,    start_d;
  logic       stop_q,     stop_d;
  logic       nack_q,     nack_d;

  // Decoded bus events, all in the synchronized domain.
  logic       scl_s;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_cond;
  logic       stop_cond;
  logic [7:0] byte_in;

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_hist_q;
  assign scl_fall   = ~scl_s & scl_hist_q;
  // SDA edges only count as START/STOP when SCL was high on both samples,
  // so a data change right at an SCL falling edge is never misread.
  assign start_cond = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_cond  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
  // Byte as it will look once the current SDA sample is shifted in (MSB first).
  assign byte_in    = {shift_q[6:0], sda_s};

  // Synchronize the bus inputs; preset high so reset looks like an idle bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_i};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
    end
  end

  // State and output registers; async clear releases the bus immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'd0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      scl_oe_q   <= 1'b0;
      wr_data_q  <= 8'd0;
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      scl_oe_q   <= scl_oe_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      rd_req_q   <= rd_req_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      nack_q     <= nack_d;
    end
  end

  // Next-state and output decode; START/STOP override any bit processing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    scl_oe_d   = scl_oe_q;
    wr_data_d  = wr_data_q;
    wr_valid_d = 1'b0;
    rd_req_d   = rd_req_q;
    busy_d     = busy_q;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    nack_d     = 1'b0;

    if (start_cond) begin
      state_d  = ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
      rd_req_d = 1'b0;
      busy_d   = 1'b0;
      start_d  = 1'b1;
    end else if (stop_cond) begin
      state_d  = IDLE;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
      rd_req_d = 1'b0;
      busy_d   = 1'b0;
      stop_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          sda_oe_d = 1'b0;
          scl_oe_d = 1'b0;
        end

        ADDR: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              if (byte_in[7:1] == SLAVE_ADDR) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = byte_in[0];
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end

        // The ACK slot spans two falling edges: the first one grabs SDA,
        // the second one releases it and moves on to the data phase.
        ADDR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              if (state_q == WR_ACK || !rw_q) begin
                state_d = WR_BYTE;
              end else begin
                // SCL is low right now, so holding it here stretches the
                // low phase until user logic supplies the byte.
                state_d  = RD_FETCH;
                rd_req_d = 1'b1;
                scl_oe_d = 1'b1;
              end
            end
          end
        end

        WR_BYTE: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d      = 4'd0;
              wr_data_d  = byte_in;
              wr_valid_d = 1'b1;
              state_d    = WR_ACK;
            end
          end
        end

        RD_FETCH: begin
          if (rd_req_q && bus.rd_valid) begin
            // MSB goes straight to the pad; the rest is kept with a trailing
            // 1 so that shift_q[7] is always the next bit to present.
            shift_d  = {bus.rd_data[6:0], 1'b1};
            sda_oe_d = ~bus.rd_data[7];
            rd_req_d = 1'b0;
            scl_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = RD_BYTE;
          end
        end

        RD_BYTE: begin
          if (scl_fall) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d    = 4'd0;
              sda_oe_d = 1'b0;
              state_d  = RD_ACK;
            end else begin
              sda_oe_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b1};
            end
          end
        end

        // cnt_q marks that an ACK was seen on the 9th rising edge, so the
        // following falling edge starts the next fetch.
        RD_ACK: begin
          if (scl_rise && cnt_q == 4'd0) begin
            if (sda_s) begin
              nack_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = WAIT_STOP;
            end else begin
              cnt_d = 4'd1;
            end
          end else if (scl_fall && cnt_q == 4'd1) begin
            cnt_d    = 4'd0;
            state_d  = RD_FETCH;
            rd_req_d = 1'b1;
            scl_oe_d = 1'b1;
          end
        end

        IGNORE, WAIT_STOP: begin
          sda_oe_d = 1'b0;
          scl_oe_d = 1'b0;
          rd_req_d = 1'b0;
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
          scl_oe_d = 1'b0;
          rd_req_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  assign bus.scl_oe    = scl_oe_q;
  assign bus.sda_oe    = sda_oe_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.rd_req    = rd_req_q;
  assign bus.busy      = busy_q;
  assign bus.start_det = start_q;
  assign bus.stop_det  = stop_q;
  assign bus.nack_rcvd = nack_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: a bit-level I2C master on an
// open-drain bus model, a user-side read responder, and event monitors.
module tb_i2c_slave_responder;

  localparam int H = 8;  // SCL half period in clk cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_slave_responder_if ifc ();

  i2c_slave_responder #(
    .SLAVE_ADDR  (7'h22),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // Open-drain bus: master lines AND the inverted target pull-downs.
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  assign ifc.scl_i = scl_m & ~ifc.scl_oe;
  assign ifc.sda_i = sda_m & ~ifc.sda_oe;

  // User-side read responder.
  int         rsp_delay = 1;
  logic       pre_valid = 1'b0;
  logic [7:0] pre_data  = 8'd0;
  logic [7:0] rsp_base  = 8'd0;
  int         rsp_mark  = 0;
  int         rsp_idx   = 0;
  int         rsp_cnt   = 0;
  logic       rsp_valid = 1'b0;

  assign ifc.rd_valid = pre_valid | rsp_valid;
  assign ifc.rd_data  = pre_valid ? pre_data : 8'(rsp_base + 8'(rsp_idx - rsp_mark));

  always @(negedge clk) begin
    if (!pre_valid && ifc.rd_req && !rsp_valid) begin
      if (rsp_cnt >= rsp_delay - 1) rsp_valid <= 1'b1;
      else                          rsp_cnt   <= rsp_cnt + 1;
    end else begin
      if (rsp_valid) rsp_idx <= rsp_idx + 1;
      rsp_valid <= 1'b0;
      rsp_cnt   <= 0;
    end
  end

  // Monitors.
  logic [7:0] wr_log  [0:255];
  int         str_log [0:255];
  int n_wr = 0, n_str = 0, n_start = 0, n_stop = 0, n_nack = 0;
  int n_rdreq = 0, n_oe = 0, n_busy = 0, run = 0;
  logic rd_req_h = 1'b0;

  always @(negedge clk) begin
    if (ifc.wr_valid) begin
      wr_log[n_wr[7:0]] <= ifc.wr_data;
      n_wr <= n_wr + 1;
    end
    if (ifc.scl_oe) run <= run + 1;
    else if (run != 0) begin
      str_log[n_str[7:0]] <= run;
      n_str <= n_str + 1;
      run   <= 0;
    end
    if (ifc.start_det) n_start <= n_start + 1;
    if (ifc.stop_det)  n_stop  <= n_stop + 1;
    if (ifc.nack_rcvd) n_nack  <= n_nack + 1;
    rd_req_h <= ifc.rd_req;
    if (ifc.rd_req && !rd_req_h) n_rdreq <= n_rdreq + 1;
    if (ifc.sda_oe || ifc.scl_oe) n_oe <= n_oe + 1;
    if (ifc.busy) n_busy <= n_busy + 1;
  end

  int checks = 0;
  int errors = 0;
  int hang   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic bus_scl();
    return scl_m & ~ifc.scl_oe;
  endfunction

  function automatic logic bus_sda();
    return sda_m & ~ifc.sda_oe;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Release SCL and wait (bounded) for the target to stop stretching.
  task automatic scl_up();
    int k;
    scl_m = 1'b1;
    k = 0;
    while (bus_scl() !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (bus_scl() !== 1'b1) hang++;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    scl_up();
    wait_clk(H);
    sda_m = 1'b0;
    wait_clk(H);
    scl_m = 1'b0;
  endtask

  task automatic i2c_rstart();
    wait_clk(2);
    sda_m = 1'b1;
    wait_clk(H - 2);
    scl_up();
    wait_clk(H);
    sda_m = 1'b0;
    wait_clk(H);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(2);
    sda_m = 1'b0;
    wait_clk(H - 2);
    scl_up();
    wait_clk(H);
    sda_m = 1'b1;
    wait_clk(H);
  endtask

  task automatic put_bit(input logic b);
    wait_clk(2);
    sda_m = b;
    wait_clk(H - 2);
    scl_up();
    wait_clk(H);
    scl_m = 1'b0;
  endtask

  task automatic get_bit(output logic b);
    wait_clk(2);
    sda_m = 1'b1;
    wait_clk(H - 2);
    scl_up();
    wait_clk(H);
    b = bus_sda();
    scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  initial begin
    logic       ack, ack2;
    logic [7:0] d;
    int acks, bad, s0, p0, w0, st0, q0, k0, o0, b0;

    // Reset state.
    #1 rst = 1'b0;
    wait_clk(4);
    chk("rst_scl_oe",   32'(ifc.scl_oe),   0);
    chk("rst_sda_oe",   32'(ifc.sda_oe),   0);
    chk("rst_wr_valid", 32'(ifc.wr_valid), 0);
    chk("rst_rd_req",   32'(ifc.rd_req),   0);
    chk("rst_busy",     32'(ifc.busy),     0);
    chk("rst_wr_data",  32'(ifc.wr_data),  0);
    chk("rst_strobes",  32'({ifc.start_det, ifc.stop_det, ifc.nack_rcvd}), 0);
    rst = 1'b1;
    wait_clk(4);

    // Write 0x44 then 0x00..0x1F.
    s0 = n_start; p0 = n_stop; w0 = n_wr;
    i2c_start();
    write_byte(8'h44, ack);
    acks = (ack == 1'b0) ? 1 : 0;
    chk("wr_busy_after_match", 32'(ifc.busy), 1);
    for (int i = 0; i < 32; i++) begin
      write_byte(8'(i), ack);
      if (ack == 1'b0) acks++;
    end
    i2c_stop();
    wait_clk(4);
    chk("wr_acks", 32'(acks), 33);
    chk("wr_count", 32'(n_wr - w0), 32);
    for (int i = 0; i < 32; i++)
      chk($sformatf("wr_data_%0d", i), 32'(wr_log[8'(w0 + i)]), 32'(i));
    chk("wr_start_det", 32'(n_start - s0), 1);
    chk("wr_stop_det",  32'(n_stop - p0), 1);
    chk("wr_busy_after_stop", 32'(ifc.busy), 0);

    // Read 32 bytes with a 50-cycle user latency, NACK the last.
    rsp_base = 8'd100; rsp_mark = rsp_idx; rsp_delay = 50;
    st0 = n_str; q0 = n_rdreq; k0 = n_nack;
    i2c_start();
    write_byte(8'h45, ack);
    chk("rd_addr_ack", 32'(ack), 0);
    for (int i = 0; i < 32; i++) begin
      read_byte(i == 31, d);
      chk($sformatf("rd_data_%0d", i), 32'(d), 32'(100 + i));
    end
    chk("rd_busy_after_nack", 32'(ifc.busy), 0);
    i2c_stop();
    wait_clk(4);
    chk("rd_stretch_count", 32'(n_str - st0), 32);
    chk("rd_stretch_first", 32'(str_log[8'(st0)]), 50);
    bad = 0;
    for (int i = 0; i < 32; i++) if (str_log[8'(st0 + i)] != 50) bad++;
    chk("rd_stretch_len_bad", 32'(bad), 0);
    chk("rd_nack_pulses", 32'(n_nack - k0), 1);
    chk("rd_req_count", 32'(n_rdreq - q0), 32);

    // Address mismatch.
    o0 = n_oe; b0 = n_busy; w0 = n_wr; p0 = n_stop;
    i2c_start();
    write_byte(8'h46, ack);
    chk("mm_addr_nack", 32'(ack), 1);
    write_byte(8'hA5, ack);
    write_byte(8'h5A, ack2);
    chk("mm_data_nack", 32'({ack, ack2}), 3);
    write_byte(8'h00, ack);
    chk("mm_data_nack_zero", 32'(ack), 1);
    i2c_stop();
    wait_clk(4);
    chk("mm_oe_cycles",   32'(n_oe - o0), 0);
    chk("mm_busy_cycles", 32'(n_busy - b0), 0);
    chk("mm_wr_valid",    32'(n_wr - w0), 0);
    chk("mm_stop_det",    32'(n_stop - p0), 1);

    // Repeated START: write 0x40, then read 0x3F already valid on request.
    s0 = n_start; st0 = n_str;
    pre_data = 8'h3F; pre_valid = 1'b1;
    i2c_start();
    write_byte(8'h44, ack);
    write_byte(8'h40, ack2);
    chk("rs_write_acks", 32'({ack, ack2}), 0);
    i2c_rstart();
    write_byte(8'h45, ack);
    chk("rs_read_addr_ack", 32'(ack), 0);
    read_byte(1'b1, d);
    i2c_stop();
    pre_valid = 1'b0;
    wait_clk(4);
    chk("rs_wr_data", 32'(wr_log[8'(n_wr - 1)]), 32'h40);
    chk("rs_rd_data", 32'(d), 32'h3F);
    chk("rs_start_det", 32'(n_start - s0), 2);
    chk("rs_stretch_count", 32'(n_str - st0), 1);
    chk("rs_stretch_len", 32'(str_log[8'(st0)]), 1);

    // Reset in the middle of a read byte while SDA is pulled low.
    rsp_base = 8'h00; rsp_mark = rsp_idx; rsp_delay = 3;
    i2c_start();
    write_byte(8'h45, ack);
    chk("mr_addr_ack", 32'(ack), 0);
    for (int i = 0; i < 4; i++) get_bit(ack);
    wait_clk(5);
    chk("mr_sda_oe_before", 32'(ifc.sda_oe), 1);
    rst = 1'b0;
    #1;
    chk("mr_sda_oe_async", 32'(ifc.sda_oe), 0);
    chk("mr_scl_oe_async", 32'(ifc.scl_oe), 0);
    chk("mr_busy_async",   32'(ifc.busy),   0);
    chk("mr_rd_req_async", 32'(ifc.rd_req), 0);
    sda_m = 1'b1; scl_m = 1'b1;
    wait_clk(4);
    rst = 1'b1;
    wait_clk(4);
    i2c_start();
    write_byte(8'h44, ack);
    write_byte(8'h55, ack2);
    chk("mr_after_acks", 32'({ack, ack2}), 0);
    i2c_stop();
    wait_clk(4);
    chk("mr_after_wr_data", 32'(wr_log[8'(n_wr - 1)]), 32'h55);

    // Back-to-back single-byte writes and reads.
    rsp_delay = 2;
    for (int i = 0; i < 64; i++) begin
      if (i % 2 == 0) begin
        i2c_start();
        write_byte(8'h44, ack);
        write_byte(8'(8'h40 + i), ack2);
        i2c_stop();
        wait_clk(2);
        chk($sformatf("b2b_wack_%0d", i), 32'({ack, ack2}), 0);
        chk($sformatf("b2b_wdata_%0d", i), 32'(wr_log[8'(n_wr - 1)]), 32'(8'h40 + i));
      end else begin
        rsp_base = 8'(63 - i); rsp_mark = rsp_idx;
        i2c_start();
        write_byte(8'h45, ack);
        read_byte(1'b1, d);
        i2c_stop();
        chk($sformatf("b2b_rack_%0d", i), 32'(ack), 0);
        chk($sformatf("b2b_rdata_%0d", i), 32'(d), 32'(63 - i));
      end
    end

    chk("no_bus_hang", 32'(hang), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
